// File: rtl/adder_exerciser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_exerciser_pkg
//  Purpose  : Shared types, constants and reference functions for the
//             one-bit full-adder exerciser.
//  Contents : state_e     - exerciser FSM states
//             expect_t    - {s, cout, valid} record carried by the expect pipe
//             NUM_VECTORS - number of {A,B,Cin} combinations driven per run
//             exp_sum()   - expected sum of vector i (parity)
//             exp_cout()  - expected carry of vector i (majority)
//  Revision : 1.0 - initial release
// ============================================================================
package adder_exerciser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic s;
        logic cout;
        logic valid;
    } expect_t;

    localparam int NUM_VECTORS = 8;

    function automatic logic exp_sum(input logic [2:0] i);
        return ^i;
    endfunction

    function automatic logic exp_cout(input logic [2:0] i);
        return (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_exerciser_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_exerciser_if
//  Purpose  : Link between the exerciser (initiator) and the far-side
//             registered full adder.
//  Signals  : A, B, Cin - stimulus, initiator -> adder
//             S, Cout   - response, adder -> initiator
//  Modports : master - exerciser side
//             slave  - adder side
//  Revision : 1.0 - initial release
// ============================================================================
interface adder_exerciser_if;
    logic A;
    logic B;
    logic Cin;
    logic S;
    logic Cout;

    modport master (output A, output B, output Cin, input S, input Cout);
    modport slave  (input A, input B, input Cin, output S, output Cout);
endinterface
`default_nettype wire

// File: rtl/adder_exerciser_expect_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : expect_pipe
//  Purpose  : LATENCY-deep shift register carrying the expected response of
//             each launched vector, so it emerges on the edge that samples
//             the adder's answer for that vector.
//  Ports    : clk    in  clock, rising edge
//             rst_n  in  asynchronous active-low reset, clears every stage
//             d_i    in  expected {s, cout, valid} entering on launch
//             q_o    out expected {s, cout, valid} due for compare now
//  Params   : LATENCY - number of stages (1..15)
//  Revision : 1.0 - initial release
// ============================================================================
module expect_pipe
    import adder_exerciser_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  expect_t d_i,
    output expect_t q_o
);

    expect_t stage_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/adder_exerciser.sv
`default_nettype none
// ============================================================================
//  Module   : adder_exerciser
//  Purpose  : On a start pulse, drives all eight {A,B,Cin} combinations into
//             the far-side registered full adder (one per cycle, A = MSB),
//             compares each returned {S,Cout} with the expected value LATENCY
//             edges later and reports pass / saturating error count.
//  Ports    : clk          in  clock, rising edge
//             rst_n        in  asynchronous active-low reset
//             start_i      in  run request, sampled only in IDLE
//             err_inject_i in  (ADDER_EXERCISER_ERRINJ_EN only) invert the
//                              expected S of vector 5 for this run
//             busy_o       out high in DRIVE and DRAIN
//             done_o       out one-cycle pulse at end of run
//             pass_o       out err_count == 0 at end of run, held to next start
//             err_count_o  out mismatching vectors, saturating
//             vec_idx_o    out index of vector currently driven
//             link         master side of adder_exerciser_if
//  Params   : LATENCY (1..15) launch-to-sample edges, ERR_W error count width
//  Macro    : ADDER_EXERCISER_ERRINJ_EN - adds err_inject_i self-test input
//  Revision : 1.0 - initial release
// ============================================================================
module adder_exerciser
    import adder_exerciser_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int ERR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
`ifdef ADDER_EXERCISER_ERRINJ_EN
    input  logic             err_inject_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [2:0]       vec_idx_o,
    adder_exerciser_if.master link
);

    localparam logic [1:0]       c_IDLE    = ST_IDLE;
    localparam logic [1:0]       c_DRIVE   = ST_DRIVE;
    localparam logic [1:0]       c_DRAIN   = ST_DRAIN;
    localparam logic [1:0]       c_DONE    = ST_DONE;
    localparam logic [2:0]       c_LAST    = 3'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] c_ERR_ONE = ERR_W'(1);
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    logic [1:0]       state_q,   state_d;
    logic [2:0]       idx_q,     idx_d;
    logic [2:0]       stim_q,    stim_d;    // {A, B, Cin}
    logic [ERR_W-1:0] err_q,     err_d;
    logic             pass_q,    pass_d;
    logic [2:0]       cmp_cnt_q, cmp_cnt_d; // compares completed this run
`ifdef ADDER_EXERCISER_ERRINJ_EN
    logic             inj_q,     inj_d;
    logic             w_inj_cur;
`endif

    logic             w_launch;
    logic [2:0]       w_launch_idx;
    expect_t          w_exp_in;
    expect_t          w_exp_out;
    logic             w_mismatch;
    logic             w_last_cmp;

    expect_pipe #(
        .LATENCY (LATENCY)
    ) u_expect_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (w_exp_in),
        .q_o   (w_exp_out)
    );

    assign w_mismatch = (link.S != w_exp_out.s) || (link.Cout != w_exp_out.cout);
    // The eighth compare of a run is the last; it may land while still in
    // DRIVE when LATENCY is 1.
    assign w_last_cmp = w_exp_out.valid && (cmp_cnt_q == c_LAST);

`ifdef ADDER_EXERCISER_ERRINJ_EN
    // Vector 0 launches on the accepting edge, before inj_q is loaded.
    assign w_inj_cur = (state_q == c_IDLE) ? err_inject_i : inj_q;
    assign w_exp_in.s = exp_sum(w_launch_idx) ^ (w_inj_cur && (w_launch_idx == 3'd5));
`else
    assign w_exp_in.s = exp_sum(w_launch_idx);
`endif
    assign w_exp_in.cout  = exp_cout(w_launch_idx);
    assign w_exp_in.valid = w_launch;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        stim_d       = stim_q;
        err_d        = err_q;
        pass_d       = pass_q;
        cmp_cnt_d    = cmp_cnt_q;
        w_launch     = 1'b0;
        w_launch_idx = 3'd0;
`ifdef ADDER_EXERCISER_ERRINJ_EN
        inj_d        = inj_q;
`endif

        if (w_exp_out.valid) begin
            cmp_cnt_d = cmp_cnt_q + 3'd1;
            if (w_mismatch && (err_q != c_ERR_MAX)) begin
                err_d = err_q + c_ERR_ONE;
            end
        end

        case (state_q)
            c_IDLE: begin
                stim_d = 3'd0;
                idx_d  = 3'd0;
                if (start_i) begin
                    state_d   = c_DRIVE;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    cmp_cnt_d = 3'd0;
                    w_launch  = 1'b1;
`ifdef ADDER_EXERCISER_ERRINJ_EN
                    inj_d     = err_inject_i;
`endif
                end
            end
            c_DRIVE: begin
                if (idx_q != c_LAST) begin
                    idx_d        = idx_q + 3'd1;
                    stim_d       = idx_q + 3'd1;
                    w_launch     = 1'b1;
                    w_launch_idx = idx_q + 3'd1;
                end else begin
                    stim_d  = 3'd0;
                    state_d = w_last_cmp ? c_DONE : c_DRAIN;
                end
            end
            c_DRAIN: begin
                stim_d = 3'd0;
                if (w_last_cmp) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Verdict is taken from the count including the final compare.
        if ((state_d == c_DONE) && (state_q != c_DONE)) begin
            pass_d = (err_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_IDLE;
            idx_q     <= 3'd0;
            stim_q    <= 3'd0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            cmp_cnt_q <= 3'd0;
`ifdef ADDER_EXERCISER_ERRINJ_EN
            inj_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            stim_q    <= stim_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            cmp_cnt_q <= cmp_cnt_d;
`ifdef ADDER_EXERCISER_ERRINJ_EN
            inj_q     <= inj_d;
`endif
        end
    end

    assign link.A      = stim_q[2];
    assign link.B      = stim_q[1];
    assign link.Cin    = stim_q[0];
    assign busy_o      = (state_q == c_DRIVE) || (state_q == c_DRAIN);
    assign done_o      = (state_q == c_DONE);
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign vec_idx_o   = idx_q;

endmodule
`default_nettype wire
